// File: rtl/connect4_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | connect4_pkg: board geometry, keycodes and disc FSM state type.      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package connect4_pkg;

  localparam int NUM_COLS = 7;
  localparam int NUM_ROWS = 6;
  localparam int CELL     = 64;
  localparam int X0       = 96;
  localparam int Y0       = 64;
  localparam int HOVER_Y  = 32;

  localparam logic [7:0] KEY_A     = 8'h04;
  localparam logic [7:0] KEY_D     = 8'h07;
  localparam logic [7:0] KEY_SPACE = 8'h2C;

  typedef enum logic [1:0] {
    HOVER = 2'd0,
    FALL  = 2'd1,
    LAND  = 2'd2,
    DONE  = 2'd3
  } disc_state_t;

  function automatic logic [9:0] col_centre(input logic [2:0] col);
    return 10'(X0 + CELL / 2) + 10'({col, 6'b0});
  endfunction

  function automatic logic [9:0] row_centre(input logic [2:0] row);
    return 10'(Y0 + CELL / 2) + 10'({row, 6'b0});
  endfunction

endpackage
`default_nettype wire

// File: rtl/col_height_table.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | col_height_table: per-column fill counters plus total placed count.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module col_height_table
  import connect4_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] i_sel,
  input  logic       i_inc,
  output logic [2:0] o_height,
  output logic       o_full,
  output logic [5:0] o_total
);

  logic [NUM_COLS-1:0][2:0] r_h;
  logic [5:0]               r_total;
  logic [2:0]               w_height;
  logic                     w_inc_ok;

  always_comb begin
    w_height = 3'd0;
    for (int c = 0; c < NUM_COLS; c++) begin
      if (i_sel == 3'(c)) w_height = r_h[c];
    end
  end

  // A full column never counts past the row limit, even if strobed.
  assign w_inc_ok = i_inc && (w_height != 3'(NUM_ROWS));

  generate
    for (genvar c = 0; c < NUM_COLS; c++) begin : g_col
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_h[c] <= 3'd0;
        end else if (w_inc_ok && (i_sel == 3'(c))) begin
          r_h[c] <= r_h[c] + 3'd1;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_total <= 6'd0;
    end else if (w_inc_ok) begin
      r_total <= r_total + 6'd1;
    end
  end

  assign o_height = w_height;
  assign o_total  = r_total;
  assign o_full   = (r_total == 6'(NUM_COLS * NUM_ROWS));

endmodule
`default_nettype wire

// File: rtl/disc_drop.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | disc_drop: keyboard-driven hovering/falling Connect Four disc.       |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module disc_drop
  import connect4_pkg::*;
#(
  parameter int         STEP      = 8,
  parameter logic [7:0] KEY_LEFT  = KEY_A,
  parameter logic [7:0] KEY_RIGHT = KEY_D,
  parameter logic [7:0] KEY_DROP  = KEY_SPACE
) (
  input  logic       frame_clk,
  input  logic       Reset,
  input  logic [7:0] keycode,
  output logic [9:0] DiscX,
  output logic [9:0] DiscY,
  output logic       Player,
  output logic       Placed,
  output logic [2:0] PlacedCol,
  output logic [2:0] PlacedRow,
  output logic       BoardFull
);

  localparam logic [9:0] STEP_PX   = 10'(STEP);
  localparam logic [9:0] HOVER_PX  = 10'(HOVER_Y);
  localparam logic [2:0] LAST_COL  = 3'(NUM_COLS - 1);
  localparam logic [2:0] ROW_LIMIT = 3'(NUM_ROWS);
  localparam logic [5:0] LAST_DISC = 6'(NUM_COLS * NUM_ROWS - 1);

  disc_state_t r_state, w_state_nxt;
  logic [2:0]  r_col, w_col_nxt;
  logic [9:0]  r_x;
  logic [9:0]  r_y, w_y_nxt;
  logic [9:0]  r_target, w_target_nxt;
  logic        r_player, w_player_nxt;
  logic        r_placed, w_placed_nxt;
  logic [2:0]  r_pcol, w_pcol_nxt;
  logic [2:0]  r_prow, w_prow_nxt;
  logic [7:0]  r_prev_key;
  logic        w_edge;
  logic        w_inc;
  logic [2:0]  w_height;
  logic        w_full;
  logic [5:0]  w_total;

  col_height_table u_heights (
    .clk     (frame_clk),
    .rst     (Reset),
    .i_sel   (r_col),
    .i_inc   (w_inc),
    .o_height(w_height),
    .o_full  (w_full),
    .o_total (w_total)
  );

  assign w_edge = (keycode != 8'h00) && (r_prev_key == 8'h00);

  always_comb begin
    w_state_nxt  = r_state;
    w_col_nxt    = r_col;
    w_y_nxt      = r_y;
    w_target_nxt = r_target;
    w_player_nxt = r_player;
    w_placed_nxt = 1'b0;
    w_pcol_nxt   = r_pcol;
    w_prow_nxt   = r_prow;
    w_inc        = 1'b0;
    case (r_state)
      HOVER: begin
        if (w_edge) begin
          if (keycode == KEY_LEFT) begin
            if (r_col != 3'd0) w_col_nxt = r_col - 3'd1;
          end else if (keycode == KEY_RIGHT) begin
            if (r_col != LAST_COL) w_col_nxt = r_col + 3'd1;
          end else if ((keycode == KEY_DROP) && (w_height != ROW_LIMIT)) begin
            w_target_nxt = row_centre(3'd5 - w_height);
            w_state_nxt  = FALL;
          end
        end
      end
      FALL: begin
        if ((r_y + STEP_PX) >= r_target) begin
          w_y_nxt      = r_target;
          w_state_nxt  = LAND;
          w_placed_nxt = 1'b1;
          w_pcol_nxt   = r_col;
          w_prow_nxt   = 3'd5 - w_height;
        end else begin
          w_y_nxt = r_y + STEP_PX;
        end
      end
      LAND: begin
        // Height is bumped on this edge, so the placed row was latched on entry.
        w_inc   = 1'b1;
        w_y_nxt = HOVER_PX;
        if (w_total == LAST_DISC) begin
          w_state_nxt = DONE;
        end else begin
          w_state_nxt  = HOVER;
          w_player_nxt = ~r_player;
        end
      end
      DONE: begin
        w_y_nxt = HOVER_PX;
      end
      default: begin
        w_state_nxt = HOVER;
      end
    endcase
  end

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      r_state    <= HOVER;
      r_col      <= 3'd3;
      r_x        <= col_centre(3'd3);
      r_y        <= HOVER_PX;
      r_target   <= HOVER_PX;
      r_player   <= 1'b0;
      r_placed   <= 1'b0;
      r_pcol     <= 3'd0;
      r_prow     <= 3'd0;
      r_prev_key <= 8'h00;
    end else begin
      r_state    <= w_state_nxt;
      r_col      <= w_col_nxt;
      r_x        <= col_centre(w_col_nxt);
      r_y        <= w_y_nxt;
      r_target   <= w_target_nxt;
      r_player   <= w_player_nxt;
      r_placed   <= w_placed_nxt;
      r_pcol     <= w_pcol_nxt;
      r_prow     <= w_prow_nxt;
      r_prev_key <= keycode;
    end
  end

  assign DiscX     = r_x;
  assign DiscY     = r_y;
  assign Player    = r_player;
  assign Placed    = r_placed;
  assign PlacedCol = r_pcol;
  assign PlacedRow = r_prow;
  assign BoardFull = w_full;

endmodule
`default_nettype wire

// File: tb/tb_disc_drop.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_disc_drop: randomized bench against a frame-level behavioural model.|
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_disc_drop;

  localparam int         STEP    = 8;
  localparam logic [7:0] K_LEFT  = 8'h04;
  localparam logic [7:0] K_RIGHT = 8'h07;
  localparam logic [7:0] K_DROP  = 8'h2C;
  localparam logic [7:0] K_OTHER = 8'h15;
  localparam int PH_HOVER = 0, PH_FALL = 1, PH_LAND = 2, PH_DONE = 3;

  logic       frame_clk = 1'b0;
  logic       Reset     = 1'b0;
  logic [7:0] keycode   = 8'h00;
  logic [9:0] DiscX, DiscY;
  logic       Player, Placed, BoardFull;
  logic [2:0] PlacedCol, PlacedRow;

  disc_drop #(.STEP(STEP)) dut (
    .frame_clk(frame_clk),
    .Reset    (Reset),
    .keycode  (keycode),
    .DiscX    (DiscX),
    .DiscY    (DiscY),
    .Player   (Player),
    .Placed   (Placed),
    .PlacedCol(PlacedCol),
    .PlacedRow(PlacedRow),
    .BoardFull(BoardFull)
  );

  always #5 frame_clk = ~frame_clk;

  int checks = 0;
  int failures = 0;
  int placed_seen = 0;
  bit chk_en = 1'b0;

  // Model: what the board and disc should look like, frame by frame.
  int         m_col, m_player, m_y, m_phase, m_fall_left, m_target;
  int         m_placed, m_pcol, m_prow, m_total;
  int         m_h[7];
  logic [7:0] m_prev;

  task automatic cmp(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_col = 3; m_player = 0; m_y = 32; m_phase = PH_HOVER;
    m_fall_left = 0; m_target = 32; m_placed = 0; m_pcol = 0; m_prow = 0;
    m_total = 0; m_prev = 8'h00;
    for (int c = 0; c < 7; c++) m_h[c] = 0;
  endtask

  task automatic model_step(input logic [7:0] k);
    bit ev;
    ev = (k != 8'h00) && (m_prev == 8'h00);
    m_prev = k;
    m_placed = 0;
    case (m_phase)
      PH_HOVER: if (ev) begin
        if (k == K_LEFT) m_col = (m_col > 0) ? m_col - 1 : 0;
        else if (k == K_RIGHT) m_col = (m_col < 6) ? m_col + 1 : 6;
        else if (k == K_DROP && m_h[m_col] < 6) begin
          m_target = 96 + 64 * (5 - m_h[m_col]);
          m_fall_left = (m_target - 32) / STEP;
          m_phase = PH_FALL;
        end
      end
      PH_FALL: begin
        m_fall_left--;
        if (m_fall_left == 0) begin
          m_y = m_target; m_phase = PH_LAND; m_placed = 1;
          m_pcol = m_col; m_prow = 5 - m_h[m_col];
        end else begin
          m_y += STEP;
        end
      end
      PH_LAND: begin
        m_h[m_col]++; m_total++; m_y = 32;
        if (m_total == 42) m_phase = PH_DONE;
        else begin m_phase = PH_HOVER; m_player ^= 1; end
      end
      default: ;
    endcase
  endtask

  always @(posedge frame_clk or posedge Reset) begin
    if (Reset) model_reset();
    else model_step(keycode);
  end

  always @(negedge frame_clk) begin
    if (chk_en) begin
      cmp("DiscX", DiscX, 128 + 64 * m_col);
      cmp("DiscY", DiscY, m_y);
      cmp("Player", Player, m_player);
      cmp("Placed", Placed, m_placed);
      cmp("PlacedCol", PlacedCol, m_pcol);
      cmp("PlacedRow", PlacedRow, m_prow);
      cmp("BoardFull", BoardFull, (m_total == 42) ? 1 : 0);
      if (Placed) placed_seen++;
    end
  end

  function automatic logic [7:0] junk_key();
    case ($urandom_range(0, 4))
      0: return 8'h00;
      1: return K_LEFT;
      2: return K_RIGHT;
      3: return K_DROP;
      default: return K_OTHER;
    endcase
  endfunction

  task automatic frame(input logic [7:0] k);
    keycode = k;
    @(negedge frame_clk); #1;
  endtask

  task automatic press(input logic [7:0] k);
    frame(k);
    frame(8'h00);
  endtask

  task automatic wait_placed(input bit junk, output int n);
    bit ok;
    n = 0; ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge frame_clk);
      n++;
      if (Placed) ok = 1'b1;
      #1;
      if (junk && !ok) keycode = junk_key();
    end
    cmp("wait_placed_timeout", ok, 1);
  endtask

  task automatic drop_here(output int n);
    frame(K_DROP);
    keycode = 8'h00;
    wait_placed(1'b0, n);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int n, ps, c, guard;
    #1 Reset = 1'b1;
    @(negedge frame_clk); #1;
    chk_en = 1'b1;
    frame(8'h00);
    Reset = 1'b0;
    cmp("rst_DiscX", DiscX, 320);
    cmp("rst_DiscY", DiscY, 32);
    cmp("rst_Player", Player, 0);
    repeat (5) frame(8'h00);
    cmp("idle_no_placed", placed_seen, 0);
    cmp("idle_DiscX", DiscX, 320);

    repeat (6) press(K_LEFT);
    cmp("left_clamp_DiscX", DiscX, 128);
    repeat (10) frame(K_RIGHT);
    frame(8'h00);
    cmp("held_right_DiscX", DiscX, 192);

    repeat (2) press(K_RIGHT);
    drop_here(n);
    cmp("bottom_fall_frames", n, 48);
    cmp("land_DiscY", DiscY, 416);
    cmp("land_PlacedCol", PlacedCol, 3);
    cmp("land_PlacedRow", PlacedRow, 5);
    frame(8'h00);
    cmp("after_land_Player", Player, 1);
    cmp("after_land_DiscY", DiscY, 32);

    repeat (3) press(K_LEFT);
    for (int i = 0; i < 6; i++) begin
      drop_here(n);
      cmp("col0_PlacedRow", PlacedRow, 5 - i);
      if (i == 5) cmp("top_fall_frames", n, 8);
      frame(8'h00);
    end
    ps = placed_seen;
    frame(K_DROP);
    repeat (60) frame(8'h00);
    cmp("full_col_no_placed", placed_seen - ps, 0);
    cmp("full_col_DiscY", DiscY, 32);

    repeat (3) press(K_RIGHT);
    frame(K_DROP);
    frame(8'h00); frame(K_LEFT); frame(8'h00); frame(K_RIGHT);
    frame(8'h00); frame(K_DROP); frame(8'h00);
    wait_placed(1'b0, n);
    cmp("fall_keys_PlacedCol", PlacedCol, 3);
    cmp("fall_keys_PlacedRow", PlacedRow, 4);
    frame(8'h00);

    frame(K_DROP);
    keycode = 8'h00;
    repeat (5) frame(8'h00);
    ps = placed_seen;
    Reset = 1'b1;
    frame(8'h00);
    Reset = 1'b0;
    cmp("midfall_rst_DiscY", DiscY, 32);
    cmp("midfall_rst_DiscX", DiscX, 320);
    cmp("midfall_rst_Player", Player, 0);
    repeat (60) frame(8'h00);
    cmp("midfall_rst_no_placed", placed_seen - ps, 0);

    guard = 0;
    while (m_total < 42 && guard < 100) begin
      guard++;
      do c = $urandom_range(0, 6); while (m_h[c] >= 6);
      for (int g = 0; g < 20 && m_col != c; g++) begin
        if ($urandom_range(0, 3) == 0) press(K_OTHER);
        press((m_col > c) ? K_LEFT : K_RIGHT);
      end
      frame(K_DROP);
      keycode = junk_key();
      wait_placed(1'b1, n);
      frame(8'h00);
    end
    cmp("fill_total", m_total, 42);
    cmp("full_BoardFull", BoardFull, 1);
    ps = placed_seen;
    repeat (80) frame(junk_key());
    frame(8'h00);
    cmp("done_no_placed", placed_seen - ps, 0);
    cmp("done_DiscY", DiscY, 32);
    cmp("done_BoardFull", BoardFull, 1);

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
